hazard3_apb_initiator: RTL

Single-outstanding APB3 requester (initiator) that turns a valid/ready request/response interface into APB setup/access transfers. It sits between a CPU-side bus adapter and APB completers such as the RISC-V timer and UART. It supports completer wait states (pready), error (pslverr), and an optional bus timeout that terminates a hung access with an error.

---
 rtl/hazard3_apb_initiator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard3_apb_initiator.sv
// Single-outstanding APB3 initiator: valid/ready request in, SETUP/ACCESS out.
// Ports: req_* upstream request, rsp_* response, p* APB3 initiator side.
module hazard3_apb_initiator #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CW =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TO_LIM = (CW + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] paddr_q;
  logic [ADDR_W-1:0] paddr_d;
  logic              pwrite_q;
  logic              pwrite_d;
  logic [31:0]       pwdata_q;
  logic [31:0]       pwdata_d;
  logic              psel_q;
  logic              psel_d;
  logic              penable_q;
  logic              penable_d;
  logic              rsp_valid_q;
  logic              rsp_valid_d;
  logic [31:0]       rsp_rdata_q;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_q;
  logic              rsp_err_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              timeout_hit;

  // The current ACCESS cycle is the TIMEOUT_CYCLES-th one without pready.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, cnt_q} + 1'b1) == TO_LIM);

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          pwdata_d  = req_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d = pwrite_q ? 32'd0 : prdata;
          rsp_err_d   = pslverr;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (timeout_hit) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
